// File: rtl/axis_eth_framer.sv
// -----------------------------------------------------------------------------
// axis_eth_framer
// Ethernet TX framing stage placed in front of the AXIS-to-GMII serialiser.
// Wraps a raw MAC frame (DA..payload, no FCS) with a 0x55 preamble, the 0xD5
// SFD and a trailing CRC-32 FCS. The optional build macro ETH_PAD_EN enables
// zero padding of short frames up to MIN_PAYLOAD bytes; the pad is covered by
// the CRC. Without ETH_PAD_EN the FCS directly follows the last payload byte.
//
// Output is purely combinational from state, counters and the input stream;
// payload bytes pass through with zero latency. If the input starves once the
// payload has started, a single 0x00 byte with tuser=1/tlast=1 aborts the
// frame and the rest of the input frame is discarded.
//
// Ports:
//   axis_aclk      clock
//   axis_aresetn   asynchronous active-low reset
//   s_axis_*       8-bit raw frame input (tdata, tuser error mark, tlast,
//                  tvalid, tready)
//   m_axis_*       8-bit on-wire output (tdata, tuser -> tx_er, tlast on last
//                  FCS byte or abort byte, tvalid, tready)
// -----------------------------------------------------------------------------
module axis_eth_framer #(
  parameter int MIN_PAYLOAD = 60,
  parameter int PRE_LEN     = 7
) (
  input  logic       axis_aclk,
  input  logic       axis_aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tuser,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tuser,
  output logic       m_axis_tlast,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  fcs_cnt_q, fcs_cnt_d;
  logic [31:0] crc_q, crc_d;

  logic [7:0]  mdata;
  logic        mvalid, muser, mlast, sready;

  // Reflected CRC-32, one data bit per iteration, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Byte count only has to reach MIN_PAYLOAD, so it saturates there.
  function automatic logic [15:0] cnt_sat(input logic [15:0] c);
    return (c >= 16'(MIN_PAYLOAD)) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      fcs_cnt_q  <= '0;
      crc_q      <= CRC_INIT;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_cnt_q  <= fcs_cnt_d;
      crc_q      <= crc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    fcs_cnt_d  = fcs_cnt_q;
    crc_d      = crc_q;
    mdata      = 8'h00;
    mvalid     = 1'b0;
    muser      = 1'b0;
    mlast      = 1'b0;
    sready     = 1'b0;

    unique case (state_q)
      // The first preamble byte is offered as soon as input is pending; the
      // input byte itself stays in place until PAYLOAD.
      S_IDLE: begin
        mvalid = s_axis_tvalid;
        mdata  = 8'h55;
        if (s_axis_tvalid && m_axis_tready) begin
          if (PRE_LEN <= 1) begin
            state_d = S_SFD;
          end else begin
            state_d   = S_PRE;
            pre_cnt_d = 8'd1;
          end
        end
      end
      S_PRE: begin
        mvalid = 1'b1;
        mdata  = 8'h55;
        if (m_axis_tready) begin
          if (pre_cnt_q == 8'(PRE_LEN - 1)) begin
            state_d   = S_SFD;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
      end
      S_SFD: begin
        mvalid = 1'b1;
        mdata  = 8'hD5;
        if (m_axis_tready) begin
          crc_d      = CRC_INIT;
          byte_cnt_d = '0;
          state_d    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        mvalid = 1'b1;
        if (s_axis_tvalid) begin
          mdata  = s_axis_tdata;
          muser  = s_axis_tuser;
          sready = m_axis_tready;
          if (m_axis_tready) begin
            crc_d      = crc_byte(crc_q, s_axis_tdata);
            byte_cnt_d = cnt_sat(byte_cnt_q);
            if (s_axis_tlast) begin
`ifdef ETH_PAD_EN
              state_d = (byte_cnt_q + 16'd1 < 16'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
`else
              state_d = S_FCS;
`endif
            end
          end
        end else begin
          // Starved mid-frame: the serialiser cannot idle, so abort on wire.
          mdata = 8'h00;
          muser = 1'b1;
          mlast = 1'b1;
          if (m_axis_tready) state_d = S_DRAIN;
        end
      end
`ifdef ETH_PAD_EN
      S_PAD: begin
        mvalid = 1'b1;
        mdata  = 8'h00;
        if (m_axis_tready) begin
          crc_d      = crc_byte(crc_q, 8'h00);
          byte_cnt_d = cnt_sat(byte_cnt_q);
          if (byte_cnt_q == 16'(MIN_PAYLOAD - 1)) state_d = S_FCS;
        end
      end
`endif
      S_FCS: begin
        mvalid = 1'b1;
        mdata  = ~crc_q[{fcs_cnt_q, 3'b000} +: 8];
        mlast  = (fcs_cnt_q == 2'd3);
        if (m_axis_tready) begin
          fcs_cnt_d = fcs_cnt_q + 2'd1;
          if (fcs_cnt_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        sready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign m_axis_tvalid = axis_aresetn & mvalid;
  assign m_axis_tuser  = axis_aresetn & muser;
  assign m_axis_tlast  = axis_aresetn & mlast;
  assign s_axis_tready = axis_aresetn & sready;
  assign m_axis_tdata  = axis_aresetn ? mdata : 8'h00;

endmodule

// File: tb/tb_axis_eth_framer.sv
module tb_axis_eth_framer;

  localparam int MINP = 60;
  localparam int PREL = 7;
  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {logic [7:0] d; logic u; logic l;} beat_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_tdata;
  logic       s_tuser, s_tlast, s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic       m_tuser, m_tlast, m_tvalid, m_tready;

  always #5 clk = ~clk;

  axis_eth_framer #(.MIN_PAYLOAD(MINP), .PRE_LEN(PREL)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rstn),
    .s_axis_tdata (s_tdata),
    .s_axis_tuser (s_tuser),
    .s_axis_tlast (s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready)
  );

  beat_t      exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       s_hs, m_hs, m_lhs;
  logic       mv_s, sr_s;
  logic [7:0] md_s;
  logic       stall_prev = 1'b0;
  beat_t      stall_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic int exp_beats(input int n);
`ifdef ETH_PAD_EN
    return 8 + ((n < MINP) ? MINP : n) + 4;
`else
    return 8 + n + 4;
`endif
  endfunction

  task automatic push(input logic [7:0] d, input logic u, input logic l);
    exp_q.push_back({d, u, l});
  endtask

  task automatic push_head();
    for (int i = 0; i < PREL; i++) push(8'h55, 1'b0, 1'b0);
    push(8'hD5, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input bytes_t pl, input int err_idx);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    push_head();
    foreach (pl[i]) begin
      push(pl[i], (i == err_idx), 1'b0);
      c = ref_crc(c, pl[i]);
    end
`ifdef ETH_PAD_EN
    for (int i = pl.size(); i < MINP; i++) begin
      push(8'h00, 1'b0, 1'b0);
      c = ref_crc(c, 8'h00);
    end
`endif
    c = ~c;
    push(c[7:0], 1'b0, 1'b0);
    push(c[15:8], 1'b0, 1'b0);
    push(c[23:16], 1'b0, 1'b0);
    push(c[31:24], 1'b0, 1'b1);
  endtask

  task automatic push_abort(input bytes_t pl, input int k);
    push_head();
    for (int i = 0; i < k; i++) push(pl[i], 1'b0, 1'b0);
    push(8'h00, 1'b1, 1'b1);
  endtask

  // One clock: sample at the falling edge, score any output beat, then step
  // to just after the next rising edge.
  task automatic tick();
    beat_t got, e;
    @(negedge clk);
    got = {m_tdata, m_tuser, m_tlast};
    if (stall_prev) begin
      chk("hold_vld", 32'(m_tvalid), 32'd1);
      chk("hold_beat", 32'(got), 32'(stall_beat));
    end
    stall_prev = m_tvalid && !m_tready;
    stall_beat = got;
    mv_s  = m_tvalid;
    sr_s  = s_tready;
    md_s  = m_tdata;
    m_hs  = m_tvalid && m_tready;
    s_hs  = s_tvalid && s_tready;
    m_lhs = m_hs && m_tlast;
    if (m_hs) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 32'(got), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mvld"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_srdy"}, 32'(s_tready), 32'd0);
    chk({tag, "_data"}, 32'(m_tdata), 32'd0);
    chk({tag, "_user"}, 32'(m_tuser), 32'd0);
    chk({tag, "_last"}, 32'(m_tlast), 32'd0);
  endtask

  // Drives one input frame. drop_at>=0 starves the input after that many
  // bytes; hold = leading cycles with m_tready low; rnd = random m_tready;
  // rst_at>=0 pulls reset once that many payload bytes have been accepted.
  task automatic drive(input bytes_t pl, input int err_idx, input int drop_at,
                       input int hold, input bit rnd, input int rst_at, output int beats);
    int idx, cyc, n;
    bit aborted, was_aborted, seen_last;
    idx = 0; cyc = 0; aborted = 0; seen_last = 0; beats = 0;
    n = pl.size();
    while (cyc < 4000) begin
      if (rst_at >= 0 && idx == rst_at) begin
        s_tvalid = 1'b1;
        s_tdata  = pl[idx];
        m_tready = 1'b1;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        stall_prev = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      m_tready = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      s_tvalid = (idx < n) && !(drop_at >= 0 && idx >= drop_at && !aborted);
      s_tdata  = (idx < n) ? pl[idx] : 8'h00;
      s_tuser  = (idx == err_idx);
      s_tlast  = (idx == n - 1);
      was_aborted = aborted;
      tick();
      if (cyc < hold) begin
        chk("bp_vld", 32'(mv_s), 32'd1);
        chk("bp_data", 32'(md_s), 32'h55);
        chk("bp_srdy", 32'(sr_s), 32'd0);
      end
      if (was_aborted) chk("drain_vld", 32'(mv_s), 32'd0);
      if (s_hs) idx++;
      if (m_hs) beats++;
      if (m_lhs) begin
        seen_last = 1;
        if (drop_at >= 0) aborted = 1;
      end
      cyc++;
      if (seen_last && idx == n) break;
    end
    chk("frame_done", 32'(seen_last && idx == n), 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_mvld"}, 32'(mv_s), 32'd0);
    chk({tag, "_srdy"}, 32'(sr_s), 32'd0);
    chk({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t pl, p2;
    int beats;

    rstn = 1'b0; s_tdata = 8'h00; s_tuser = 1'b0; s_tlast = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    s_tvalid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle_check("idle0");

    // "123456789" with its well-known CRC-32 0xCBF43926
    for (int i = 0; i < 9; i++) pl.push_back(8'(49 + i));
`ifdef ETH_PAD_EN
    push_frame(pl, -1);
`else
    push_head();
    foreach (pl[i]) push(pl[i], 1'b0, 1'b0);
    push(8'h26, 1'b0, 1'b0);
    push(8'h39, 1'b0, 1'b0);
    push(8'hF4, 1'b0, 1'b0);
    push(8'hCB, 1'b0, 1'b1);
`endif
    drive(pl, -1, -1, 0, 0, -1, beats);
    chk("t1_beats", 32'(beats), 32'(exp_beats(9)));
    idle_check("idle1");

    // 200 cycles of downstream backpressure before the same frame
    push_frame(pl, -1);
    drive(pl, -1, -1, 200, 0, -1, beats);
    chk("bp_beats", 32'(beats), 32'(exp_beats(9)));
    idle_check("idle2");

    // single-byte frame
    p2 = {};
    p2.push_back(8'hAA);
    push_frame(p2, -1);
    drive(p2, -1, -1, 0, 0, -1, beats);
    chk("one_beats", 32'(beats), 32'(exp_beats(1)));
    idle_check("idle3");

    // exactly MIN_PAYLOAD bytes: never padded
    p2 = {};
    for (int i = 0; i < MINP; i++) p2.push_back(8'($urandom_range(0, 255)));
    push_frame(p2, -1);
    drive(p2, -1, -1, 0, 0, -1, beats);
    chk("min_beats", 32'(beats), 32'd72);
    idle_check("idle4");

    // random backpressure, one errored byte forwarded with tuser
    p2 = {};
    for (int i = 0; i < 20; i++) p2.push_back(8'($urandom_range(0, 255)));
    push_frame(p2, 7);
    drive(p2, 7, -1, 0, 1, -1, beats);
    chk("rnd_beats", 32'(beats), 32'(exp_beats(20)));
    idle_check("idle5");

    // underrun after 5 payload bytes of 12
    p2 = {};
    for (int i = 0; i < 12; i++) p2.push_back(8'(16 + i));
    push_abort(p2, 5);
    drive(p2, -1, 5, 0, 0, -1, beats);
    chk("abort_beats", 32'(beats), 32'd14);
    idle_check("idle6");

    // next frame after the abort starts cleanly
    p2 = {};
    for (int i = 0; i < 3; i++) p2.push_back(8'(200 + i));
    push_frame(p2, -1);
    drive(p2, -1, -1, 0, 0, -1, beats);
    chk("post_abort_beats", 32'(beats), 32'(exp_beats(3)));
    idle_check("idle7");

    // reset in the middle of the payload, then a fresh frame
    p2 = {};
    for (int i = 0; i < 10; i++) p2.push_back(8'(100 + i));
    push_frame(p2, -1);
    drive(p2, -1, -1, 0, 0, 4, beats);
    chk("pre_rst_beats", 32'(beats), 32'd12);
    idle_check("idle8");
    push_frame(pl, -1);
    drive(pl, -1, -1, 0, 0, -1, beats);
    chk("post_rst_beats", 32'(beats), 32'(exp_beats(9)));
    idle_check("idle9");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_eth_framer.md
Name: axis_eth_framer

Overview:
Ethernet TX framing stage that sits directly upstream of the AXIS-to-GMII serialiser. It takes a raw MAC frame (DA..payload, no FCS) on an 8-bit AXI-Stream input and produces the complete on-wire byte stream on an AXI-Stream output: 7×0x55 preamble, 0xD5 SFD, payload, optional zero padding, then a 4-byte CRC-32 FCS. Once a frame has started, the downstream serialiser needs one byte per cycle, so an input starvation mid-payload terminates the frame with an error byte.

Parameters:
MIN_PAYLOAD, 60, minimum payload byte count before FCS; padding target when ETH_PAD_EN is defined.
PRE_LEN, 7, number of 0x55 preamble bytes before the SFD.

Ports:
axis_aclk  input  1  clock
axis_aresetn  input  1  asynchronous active-low reset
s_axis_tdata  input  8  raw frame byte
s_axis_tuser  input  1  byte error marker
s_axis_tlast  input  1  last payload byte
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  8  wire byte
m_axis_tuser  output  1  error; becomes tx_er downstream
m_axis_tlast  output  1  last FCS byte or abort byte
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready

Behaviour:
- Reset: axis_aresetn is asynchronous, active-low; the clock is axis_aclk. Reset forces state to IDLE and clears all counters. CRC is set to 0xFFFFFFFF. While reset is asserted: m_axis_tvalid=0, s_axis_tready=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0x00.
- Reset mid-frame abandons the frame immediately. No tail bytes are emitted.
- States: IDLE, PRE, SFD, PAYLOAD, PAD, FCS, DRAIN.
- Output is combinational from state, counters and the input stream. There is no registered pipeline.
- Payload latency is 0 cycles. Each frame adds 8 head beats and 4 tail beats, plus pad beats when padding applies.
- IDLE: m_tvalid=s_tvalid, m_tdata=0x55, s_tready=0. On an m handshake go to PRE with pre_cnt=1. The input byte is not consumed.
- PRE: m_tvalid=1, m_tdata=0x55, s_tready=0. pre_cnt increments on each handshake. The handshake at pre_cnt==PRE_LEN-1 goes to SFD.
- SFD: m_tvalid=1, m_tdata=0xD5. On handshake, reset CRC to 0xFFFFFFFF and byte_cnt to 0, then go to PAYLOAD.
- PAYLOAD, normal: m_tvalid=1, m_tdata=s_tdata, m_tuser=s_tuser, s_tready=m_tready, m_tlast=0.
  - Each handshake updates the CRC and byte_cnt. byte_cnt saturates at MIN_PAYLOAD.
  - On the handshake with s_tlast: go to PAD if ETH_PAD_EN is defined and byte_cnt+1 < MIN_PAYLOAD; otherwise go to FCS.
- PAYLOAD, underrun (m_tready=1 and s_tvalid=0): emit m_tdata=0x00, m_tuser=1, m_tlast=1.
  - s_tready=0, so no input byte is consumed.
  - Go to DRAIN. No FCS is sent.
- DRAIN: m_tvalid=0, s_tready=1. Discard input until the handshake with s_tlast, then go to IDLE.
  - If an input byte with tlast is accepted in the same cycle the underrun abort would occur, normal PAYLOAD rules take priority. This case cannot arise when s_tvalid=1, so there is no conflict.
- PAD: m_tvalid=1, m_tdata=0x00, m_tuser=0, s_tready=0. Each handshake updates the CRC and byte_cnt. The handshake at byte_cnt==MIN_PAYLOAD-1 goes to FCS.
- FCS: emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24], in that order, using fcs_cnt 0..3.
  - The CRC register is frozen during FCS.
  - m_tlast=1 on the 4th byte. Its handshake goes to IDLE.
- CRC-32: reflected polynomial 0xEDB88320, LSB-first, init 0xFFFFFFFF, final complement. It covers payload and pad bytes only.
- An s_tuser=1 byte is forwarded with m_tuser=1. The frame continues and the FCS is still appended.
- m_tready low at any point simply holds the state. All AXIS stability rules are met: data is held while valid && !ready.
- A single-byte frame (s_tlast on the first byte) is legal.

Optional Feature:
ETH_PAD_EN: when defined, frames shorter than MIN_PAYLOAD are zero-padded to MIN_PAYLOAD bytes before the FCS, and the pad is included in the CRC. When undefined, the PAD state and the byte_cnt compare are removed; the FCS immediately follows the last payload byte, whatever its length.

Test Plan:
- Define-off. Payload "123456789" (0x31..0x39), m_tready=1 → 55×7, D5, 31..39, then 26 39 F4 CB with tlast on CB; 21 beats total.
- Define-on. 1-byte payload 0xAA → 8 head beats, AA, then 59×0x00, 4 FCS bytes; 72 beats, tlast only on the last beat. FCS matches the reference CRC of AA followed by 59 zeros.
- Define-on. 60-byte payload → no PAD beats; 72 output beats.
- Backpressure: m_tready held low for 200 cycles with s_tvalid=1 → m_tvalid=1 with tdata=0x55 held stable and no input consumed. Then hold m_tready=1 → frame as in test 1.
- Underrun: drop s_tvalid after payload byte 5 while m_tready=1 → one beat 0x00 with tuser=1 and tlast=1, then m_tvalid=0. Remaining input bytes through tlast are accepted and discarded. The next frame starts with a clean preamble.
- Reset mid-PAYLOAD: assert axis_aresetn=0 → m_tvalid=0 and s_tready=0 asynchronously. After release, the next s_tvalid produces a fresh 0x55 preamble and the CRC restarts from 0xFFFFFFFF.
